// File: rtl/mips_bus_pkg.sv
// Shared types and lane constants for the MIPS Avalon-MM bus master.
package mips_bus_pkg;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_t;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_LO_HALF = 4'b0011;
   localparam logic [3:0] BE_HI_HALF = 4'b1100;

endpackage

// File: rtl/mips_bus_lane_fmt.sv
// Little-endian lane steering: byteenable/writedata for stores and
// right-justified, sign- or zero-extended load data.
module mips_bus_lane_fmt
   import mips_bus_pkg::*;
(
   input  size_t       size,
   input  logic [1:0]  addr_lo,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      shifted    = rdata_raw >> {addr_lo, 3'b000};
      byteenable = BE_WORD;
      writedata  = wdata;
      rdata_ext  = rdata_raw;
      case (size)
         SIZE_BYTE: begin
            byteenable = 4'b0001 << addr_lo;
            writedata  = {4{wdata[7:0]}};
            rdata_ext  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            byteenable = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
            writedata  = {2{wdata[15:0]}};
            rdata_ext  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_bus_master.sv
// Avalon-MM master arbitrating fetch and load/store channels of the MIPS core.
// Optional waitrequest watchdog enabled by defining MIPS_BUS_TIMEOUT_EN.
module mips_bus_master
   import mips_bus_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter bit          DATA_PRIORITY  = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic              i_err,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic              d_signed,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic [31:0]       d_rdata,
   output logic              busy,
   output logic              bus_timeout,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   input  logic              waitrequest,
   output logic [31:0]       writedata,
   output logic [3:0]        byteenable,
   input  logic [31:0]       readdata
);

   state_t            state;
   logic              is_data, fault, sign_q;
   size_t             size_q, d_sz, sel_size, fmt_size;
   logic [1:0]        lo_q, sel_lo, fmt_lo;
   logic              grant_d, grant_i, d_bad, i_bad, sel_bad, fmt_sign, timed_out;
   logic [ADDR_W-1:0] sel_addr;
   logic [3:0]        fmt_be;
   logic [31:0]       fmt_wd, fmt_rd;

`ifdef MIPS_BUS_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wd_cnt;
   logic             timeout_q;
   assign bus_timeout = timeout_q;
`else
   assign bus_timeout = 1'b0;
`endif

   always_comb begin
      d_sz     = size_t'(d_size);
      grant_d  = d_req && (DATA_PRIORITY || !i_req);
      grant_i  = i_req && !grant_d;
      d_bad    = (d_size == 2'b11) || (d_sz == SIZE_HALF && d_addr[0]) ||
                 (d_sz == SIZE_WORD && d_addr[1:0] != 2'b00);
      i_bad    = i_addr[1:0] != 2'b00;
      sel_bad  = grant_d ? d_bad : i_bad;
      sel_addr = grant_d ? d_addr : i_addr;
      sel_size = (grant_d && !d_bad) ? d_sz : SIZE_WORD;
      sel_lo   = grant_d ? d_addr[1:0] : 2'b00;
      // Formatter sees the live request in IDLE and the latched one during BUS.
      fmt_size = (state == IDLE) ? sel_size : size_q;
      fmt_lo   = (state == IDLE) ? sel_lo : lo_q;
      fmt_sign = (state == IDLE) ? (grant_d && d_signed) : sign_q;
`ifdef MIPS_BUS_TIMEOUT_EN
      timed_out = !fault && waitrequest && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
      timed_out = 1'b0;
`endif
   end

   mips_bus_lane_fmt u_lane_fmt (
      .size       (fmt_size),
      .addr_lo    (fmt_lo),
      .sign_ext   (fmt_sign),
      .wdata      (d_wdata),
      .rdata_raw  (readdata),
      .byteenable (fmt_be),
      .writedata  (fmt_wd),
      .rdata_ext  (fmt_rd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         read       <= 1'b0;
         write      <= 1'b0;
         address    <= '0;
         writedata  <= '0;
         byteenable <= '0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         i_err      <= 1'b0;
         d_err      <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         busy       <= 1'b0;
         is_data    <= 1'b0;
         fault      <= 1'b0;
         sign_q     <= 1'b0;
         size_q     <= SIZE_WORD;
         lo_q       <= 2'b00;
`ifdef MIPS_BUS_TIMEOUT_EN
         wd_cnt     <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         i_err <= 1'b0;
         d_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_d || grant_i) begin
                  is_data <= grant_d;
                  fault   <= sel_bad;
                  size_q  <= sel_size;
                  lo_q    <= sel_lo;
                  sign_q  <= grant_d && d_signed;
                  busy    <= 1'b1;
                  state   <= BUS;
`ifdef MIPS_BUS_TIMEOUT_EN
                  wd_cnt  <= '0;
`endif
                  // A faulty access spends its BUS cycle with strobes low so that
                  // the error ack lands at the same latency as a zero-wait transfer.
                  if (!sel_bad) begin
                     address    <= {sel_addr[ADDR_W-1:2], 2'b00};
                     read       <= !(grant_d && d_we);
                     write      <= grant_d && d_we;
                     byteenable <= fmt_be;
                     writedata  <= fmt_wd;
                  end
               end
            end
            BUS: begin
               if (fault || !waitrequest || timed_out) begin
                  read  <= 1'b0;
                  write <= 1'b0;
                  state <= RESP;
                  if (is_data) begin
                     d_ack <= 1'b1;
                     d_err <= fault || timed_out;
                  end else begin
                     i_ack <= 1'b1;
                     i_err <= fault || timed_out;
                  end
                  if (read && !waitrequest) begin
                     if (is_data) d_rdata <= fmt_rd;
                     else         i_rdata <= fmt_rd;
                  end
               end
`ifdef MIPS_BUS_TIMEOUT_EN
               if (timed_out)                   timeout_q <= 1'b1;
               else if (waitrequest && !fault) wd_cnt    <= wd_cnt + 1'b1;
`endif
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_bus_master.sv
// Scoreboard bench for mips_bus_master: byte-addressed reference memory model,
// Avalon slave responder with planned wait states, and an ack monitor.
module tb_mips_bus_master;

   logic        clk, reset;
   logic        i_req, i_ack, i_err;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_signed, d_ack, d_err;
   logic [1:0]  d_size;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        busy, bus_timeout, read, write, waitrequest;
   logic [31:0] address, writedata, readdata;
   logic [3:0]  byteenable;

   mips_bus_master u_dut (
      .clk         (clk),
      .reset       (reset),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_ack       (i_ack),
      .i_err       (i_err),
      .i_rdata     (i_rdata),
      .d_req       (d_req),
      .d_we        (d_we),
      .d_size      (d_size),
      .d_signed    (d_signed),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_ack       (d_ack),
      .d_err       (d_err),
      .d_rdata     (d_rdata),
      .busy        (busy),
      .bus_timeout (bus_timeout),
      .address     (address),
      .read        (read),
      .write       (write),
      .waitrequest (waitrequest),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .readdata    (readdata)
   );

   typedef struct {
      bit          is_data;
      bit          err;
      bit          chk_rd;
      logic [31:0] rd;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      bit          we;
      logic [31:0] wd;
      int          cyc;
   } bus_t;

   exp_t       eq[$];
   bus_t       bq[$];
   int         wq[$];
   logic [7:0] smem[256];
   logic [7:0] mmem[256];
   int         cyc;
   int         n_cmp, n_bad;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         smem[idx + b] = w[8*b +: 8];
         mmem[idx + b] = w[8*b +: 8];
      end
   endtask

   // Reference behaviour of one access, computed from byte-level memory semantics.
   task automatic model_access(input bit is_data, input bit we, input logic [1:0] size,
                               input bit sgn, input logic [31:0] addr, input logic [31:0] wd,
                               input int waits, input int cyc0, output int ack_cyc);
      int          n, a;
      exp_t        e;
      bus_t        b;
      logic [31:0] v;
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
      a = int'(addr[7:0]);
      e.is_data = is_data;
      e.rd      = '0;
      e.chk_rd  = 1'b0;
      if (n == 0 || (a % n) != 0) begin
         e.err   = 1'b1;
         ack_cyc = cyc0 + 2;
      end else begin
         e.err = 1'b0;
         wq.push_back(waits);
         b.addr = addr & ~32'd3;
         b.be   = 4'((((1 << n) - 1) << (a % 4)));
         b.we   = we;
         b.wd   = '0;
         b.cyc  = cyc0 + 1;
         for (int k = 0; k < n; k++) b.wd[8*((a % 4) + k) +: 8] = wd[8*k +: 8];
         bq.push_back(b);
         if (we) begin
            for (int k = 0; k < n; k++) mmem[a + k] = wd[8*k +: 8];
         end else begin
            v = '0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = mmem[a + k];
            if (sgn && n < 4 && v[8*n-1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
            e.rd     = v;
            e.chk_rd = 1'b1;
         end
         ack_cyc = cyc0 + 2 + waits;
      end
      e.cyc = ack_cyc;
      eq.push_back(e);
   endtask

   task automatic wait_ack(input bit data_ch);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (data_ch ? d_ack : i_ack) done = 1'b1;
         else begin
            n++;
            if (n > 80) begin
               n_cmp++;
               n_bad++;
               $display("FAIL ack_timeout: no %s ack in 80 cycles, required one",
                        data_ch ? "data" : "fetch");
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic run_data(input bit we, input logic [1:0] size, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wd, input int waits);
      int ac;
      model_access(1'b1, we, size, sgn, addr, wd, waits, cyc, ac);
      d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wd; d_req = 1'b1;
      wait_ack(1'b1);
      @(posedge clk); #1;
      d_req = 1'b0;
   endtask

   task automatic run_fetch(input logic [31:0] addr, input int waits);
      int ac;
      model_access(1'b0, 1'b0, 2'd2, 1'b0, addr, 32'd0, waits, cyc, ac);
      i_addr = addr; i_req = 1'b1;
      wait_ack(1'b0);
      @(posedge clk); #1;
      i_req = 1'b0;
   endtask

   // Both requests rise together; data is granted first, fetch follows from IDLE.
   task automatic run_both(input bit we, input logic [1:0] size, input bit sgn,
                           input logic [31:0] da, input logic [31:0] wd, input int dw,
                           input logic [31:0] ia, input int iw);
      int ac, ac2;
      model_access(1'b1, we, size, sgn, da, wd, dw, cyc, ac);
      model_access(1'b0, 1'b0, 2'd2, 1'b0, ia, 32'd0, iw, ac + 1, ac2);
      d_we = we; d_size = size; d_signed = sgn; d_addr = da; d_wdata = wd; d_req = 1'b1;
      i_addr = ia; i_req = 1'b1;
      wait_ack(1'b1);
      @(posedge clk); #1;
      d_req = 1'b0;
      wait_ack(1'b0);
      @(posedge clk); #1;
      i_req = 1'b0;
   endtask

   // Avalon slave: plays back planned wait states and applies writes by byteenable.
   initial begin : responder
      bit          active;
      int          remaining, start_cyc;
      logic [31:0] start_addr, m;
      logic [3:0]  start_be;
      bus_t        b;
      int          w;
      active      = 1'b0;
      remaining   = 0;
      waitrequest = 1'b0;
      readdata    = '0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            active      = 1'b0;
            wq.delete();
            waitrequest = 1'b0;
         end else if (read || write) begin
            if (!active) begin
               active     = 1'b1;
               remaining  = (wq.size() > 0) ? wq.pop_front() : 0;
               start_cyc  = cyc;
               start_addr = address;
               start_be   = byteenable;
            end
            if (remaining > 0) begin
               remaining--;
               waitrequest = 1'b1;
               readdata    = $urandom;
            end else begin
               waitrequest = 1'b0;
               w = int'(address[7:2]) * 4;
               readdata = {smem[w + 3], smem[w + 2], smem[w + 1], smem[w]};
               check("bus_stable_addr", address, start_addr);
               check("bus_stable_be", 32'(byteenable), 32'(start_be));
               if (bq.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL bus_unexpected: transfer at %h, required none", address);
               end else begin
                  b = bq.pop_front();
                  m = {{8{b.be[3]}}, {8{b.be[2]}}, {8{b.be[1]}}, {8{b.be[0]}}};
                  check("bus_addr", address, b.addr);
                  check("bus_write", 32'(write), 32'(b.we));
                  check("bus_read", 32'(read), 32'(!b.we));
                  check("bus_be", 32'(byteenable), 32'(b.be));
                  check("bus_start_cyc", 32'(start_cyc), 32'(b.cyc));
                  if (b.we) check("bus_wdata", writedata & m, b.wd & m);
               end
               if (write)
                  for (int k = 0; k < 4; k++)
                     if (byteenable[k]) smem[w + k] = writedata[8*k +: 8];
               active = 1'b0;
            end
         end else begin
            waitrequest = 1'($urandom_range(0, 1));
            readdata    = $urandom;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (i_ack || d_ack)) begin
            if (eq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_ack: i_ack=%b d_ack=%b, required no ack", i_ack, d_ack);
            end else begin
               e = eq.pop_front();
               check("ack_channel", 32'({i_ack, d_ack}), 32'({!e.is_data, e.is_data}));
               check("ack_err", 32'(e.is_data ? d_err : i_err), 32'(e.err));
               check("ack_cycle", 32'(cyc), 32'(e.cyc));
               check("ack_busy", 32'(busy), 32'd1);
               check("ack_timeout_flag", 32'(bus_timeout), 32'd0);
               if (e.chk_rd) check("ack_rdata", e.is_data ? d_rdata : i_rdata, e.rd);
            end
         end
      end
   end

   initial begin : driver
      logic [31:0] a, wd;
      logic [1:0]  sz;
      int          kind;
      n_cmp = 0; n_bad = 0;
      reset = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         smem[i] = 8'($urandom);
         mmem[i] = smem[i];
      end
      poke(8'h00, 32'h2402_0005);
      poke(8'h40, 32'h80FF_7F01);
      repeat (3) @(negedge clk);
      check("rst_address", address, 32'd0);
      check("rst_writedata", writedata, 32'd0);
      check("rst_byteenable", 32'(byteenable), 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_ctrl", 32'({read, write, i_ack, d_ack, i_err, d_err, busy, bus_timeout}), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_fetch(32'hBFC0_0000, 0);
      check("fetch_rdata", i_rdata, 32'h2402_0005);
      run_data(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 3);
      run_data(1'b0, 2'd0, 1'b1, 32'h0000_1042, 32'd0, 1);
      check("ld_byte_signed", d_rdata, 32'hFFFF_FFFF);
      run_data(1'b0, 2'd1, 1'b0, 32'h0000_1042, 32'd0, 0);
      check("ld_half_unsigned", d_rdata, 32'h0000_80FF);
      run_data(1'b0, 2'd0, 1'b1, 32'h0000_1040, 32'd0, 2);
      check("ld_byte_pos", d_rdata, 32'h0000_0001);
      run_both(1'b0, 2'd2, 1'b0, 32'h0000_1040, 32'd0, 0, 32'hBFC0_0000, 0);
      run_data(1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'd0, 0);
      check("misaligned_rdata_held", d_rdata, 32'h80FF_7F01);

      // Reset while the slave is stalling: transfer abandoned, no ack afterwards.
      wq.push_back(6);
      d_we = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 32'h0000_1010; d_req = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_rst_read", 32'(read), 32'd1);
      reset = 1'b1;
      d_req = 1'b0;
      @(negedge clk);
      check("rst_mid_strobes", 32'({read, write, busy}), 32'd0);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      @(posedge clk); #1;

      for (int it = 0; it < 120; it++) begin
         kind = $urandom_range(0, 9);
         a    = 32'h0000_1000 | 32'($urandom_range(0, 255));
         wd   = $urandom;
         sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
         if (kind < 3) begin
            a = 32'hBFC0_0000 | (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            run_fetch(a, $urandom_range(0, 3));
         end else if (kind < 9) begin
            run_data(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd,
                     $urandom_range(0, 3));
         end else begin
            run_both(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd,
                     $urandom_range(0, 3),
                     32'hBFC0_0000 | (32'($urandom_range(0, 63)) << 2), $urandom_range(0, 3));
         end
      end

      repeat (5) @(negedge clk);
      check("drain_ack_queue", 32'(eq.size()), 32'd0);
      check("drain_bus_queue", 32'(bq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
